// File: rtl/tile_drawer_pkg.sv
// Shared constants, types and helpers for the piano-tiles pixel-write path.
package tile_drawer_pkg;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;
    localparam int unsigned C_W = 9;
    localparam int unsigned T_W = 2;

    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned SCREEN_H_DEF = 480;
    localparam int unsigned TILE_W_DEF   = 160;
    localparam int unsigned TILE_H_DEF   = 120;
    localparam int unsigned BORDER_DEF   = 2;

    // 3:3:3 RGB palette
    localparam logic [C_W-1:0] COLOR_BLACK = 9'h000;
    localparam logic [C_W-1:0] COLOR_WHITE = 9'h1FF;
    localparam logic [C_W-1:0] COLOR_RED   = 9'h1C0;
    localparam logic [C_W-1:0] COLOR_GREEN = 9'h038;
    localparam logic [C_W-1:0] COLOR_BLUE  = 9'h007;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Geometry and colouring of the command being drawn
    typedef struct packed {
        logic [X_W-1:0] org_x;
        logic [Y_W-1:0] org_y;
        logic [X_W-1:0] w_max;
        logic [Y_W-1:0] h_max;
        logic [C_W-1:0] fill;
        logic           border_en;
    } draw_cfg_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] color;
    } pixel_t;

    // True when local (lx,ly) lies within b pixels of any edge of a (w_max+1)x(h_max+1) box
    function automatic logic in_border(
        input logic [X_W-1:0] lx,
        input logic [Y_W-1:0] ly,
        input logic [X_W-1:0] w_max,
        input logic [Y_W-1:0] h_max,
        input logic [X_W-1:0] bx,
        input logic [Y_W-1:0] by
    );
        return (lx < bx) || (lx > (w_max - bx)) || (ly < by) || (ly > (h_max - by));
    endfunction

endpackage

// File: rtl/tile_drawer_if.sv
// Command and pixel-write bundle between game logic, tile_drawer and the VGA adapter.
interface tile_drawer_if;
    import tile_drawer_pkg::*;

    logic           start;
    logic           clear;
    logic [T_W-1:0] tile_x;
    logic [T_W-1:0] tile_y;
    logic [C_W-1:0] fill_color;
    logic           border_en;
    logic           busy;
    logic           done;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] color;
    logic           write;

    modport master (
        output start, clear, tile_x, tile_y, fill_color, border_en,
        input  busy, done, x, y, color, write
    );

    modport slave (
        input  start, clear, tile_x, tile_y, fill_color, border_en,
        output busy, done, x, y, color, write
    );

endinterface

// File: rtl/tile_drawer_raster_counter.sv
// Raster-order lx/ly counter with runtime limits; exposes next values so callers can register outputs in lockstep.
module tile_drawer_raster_counter
    import tile_drawer_pkg::*;
(
    input  logic           clock,
    input  logic           resetn,
    input  logic           i_clr,
    input  logic           i_adv,
    input  logic [X_W-1:0] i_w_max,
    input  logic [Y_W-1:0] i_h_max,
    output logic [X_W-1:0] o_lx_nxt_c,
    output logic [Y_W-1:0] o_ly_nxt_c,
    output logic           o_last_c
);

    logic [X_W-1:0] r_lx;
    logic [Y_W-1:0] r_ly;
    logic [X_W-1:0] w_lx_nxt;
    logic [Y_W-1:0] w_ly_nxt;

    // Clear wins over advance; lx wraps first, ly wraps after the last row
    always_comb begin
        w_lx_nxt = r_lx;
        w_ly_nxt = r_ly;
        if (i_clr) begin
            w_lx_nxt = '0;
            w_ly_nxt = '0;
        end else if (i_adv) begin
            if (r_lx == i_w_max) begin
                w_lx_nxt = '0;
                w_ly_nxt = (r_ly == i_h_max) ? '0 : r_ly + Y_W'(1);
            end else begin
                w_lx_nxt = r_lx + X_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lx <= '0;
            r_ly <= '0;
        end else begin
            r_lx <= w_lx_nxt;
            r_ly <= w_ly_nxt;
        end
    end

    assign o_lx_nxt_c = w_lx_nxt;
    assign o_ly_nxt_c = w_ly_nxt;
    assign o_last_c   = (r_lx == i_w_max) && (r_ly == i_h_max);

endmodule

// File: rtl/tile_drawer.sv
// Turns one tile-fill or screen-clear command into a registered one-pixel-per-clock write stream.
module tile_drawer
    import tile_drawer_pkg::*;
#(
    parameter int unsigned    TILE_W       = TILE_W_DEF,
    parameter int unsigned    TILE_H       = TILE_H_DEF,
    parameter int unsigned    SCREEN_W     = SCREEN_W_DEF,
    parameter int unsigned    SCREEN_H     = SCREEN_H_DEF,
    parameter int unsigned    BORDER       = BORDER_DEF,
    parameter logic [C_W-1:0] BORDER_COLOR = COLOR_BLACK
) (
    input  logic         clock,
    input  logic         resetn,
    tile_drawer_if.slave bus
);

    localparam logic [X_W-1:0] TILE_W_V   = X_W'(TILE_W);
    localparam logic [Y_W-1:0] TILE_H_V   = Y_W'(TILE_H);
    localparam logic [X_W-1:0] TILE_W_MAX = X_W'(TILE_W - 1);
    localparam logic [Y_W-1:0] TILE_H_MAX = Y_W'(TILE_H - 1);
    localparam logic [X_W-1:0] SCR_W_MAX  = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] SCR_H_MAX  = Y_W'(SCREEN_H - 1);
    localparam logic [X_W-1:0] BORDER_X   = X_W'(BORDER);
    localparam logic [Y_W-1:0] BORDER_Y   = Y_W'(BORDER);

    state_t    r_state;
    state_t    w_state_nxt;
    draw_cfg_t r_cfg;
    draw_cfg_t w_cfg;
    pixel_t    r_pix;
    pixel_t    w_pix;
    logic      r_busy;
    logic      r_done;
    logic      r_write;
    logic      w_busy_nxt;
    logic      w_done_nxt;
    logic      w_write_nxt;
    logic      w_cnt_clr;
    logic      w_cnt_adv;
    logic      w_last;

    logic [X_W-1:0] w_lx_nxt;
    logic [Y_W-1:0] w_ly_nxt;

    tile_drawer_raster_counter u_raster (
        .clock      (clock),
        .resetn     (resetn),
        .i_clr      (w_cnt_clr),
        .i_adv      (w_cnt_adv),
        .i_w_max    (r_cfg.w_max),
        .i_h_max    (r_cfg.h_max),
        .o_lx_nxt_c (w_lx_nxt),
        .o_ly_nxt_c (w_ly_nxt),
        .o_last_c   (w_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, command capture and counter control; outputs are registered from the *_nxt values
    always_comb begin
        w_state_nxt = r_state;
        w_cfg       = r_cfg;
        w_cnt_clr   = 1'b0;
        w_cnt_adv   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_cfg.fill      = bus.fill_color;
                    w_cfg.border_en = bus.border_en && !bus.clear;
                    if (bus.clear) begin
                        w_cfg.org_x = '0;
                        w_cfg.org_y = '0;
                        w_cfg.w_max = SCR_W_MAX;
                        w_cfg.h_max = SCR_H_MAX;
                    end else begin
                        w_cfg.org_x = X_W'(bus.tile_x) * TILE_W_V;
                        w_cfg.org_y = Y_W'(bus.tile_y) * TILE_H_V;
                        w_cfg.w_max = TILE_W_MAX;
                        w_cfg.h_max = TILE_H_MAX;
                    end
                    w_cnt_clr   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_write_nxt = 1'b1;
                    w_state_nxt = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (w_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_adv   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_write_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pixel for the counter position that will be live after this edge; zero when not writing
    always_comb begin
        w_pix = '0;
        if (w_write_nxt) begin
            w_pix.x     = w_cfg.org_x + w_lx_nxt;
            w_pix.y     = w_cfg.org_y + w_ly_nxt;
            w_pix.color = (w_cfg.border_en &&
                           in_border(w_lx_nxt, w_ly_nxt, w_cfg.w_max, w_cfg.h_max, BORDER_X, BORDER_Y))
                          ? BORDER_COLOR : w_cfg.fill;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cfg   <= '0;
            r_pix   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_cfg   <= w_cfg;
            r_pix   <= w_pix;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_write <= w_write_nxt;
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.write = r_write;
    assign bus.x     = r_pix.x;
    assign bus.y     = r_pix.y;
    assign bus.color = r_pix.color;

endmodule

// File: tb/tb_tile_drawer.sv
// Directed bench for tile_drawer on a shrunken 16x12 screen with 4x3 tiles and a 1-pixel outline.
module tb_tile_drawer;
    import tile_drawer_pkg::*;

    localparam int unsigned TW = 4;
    localparam int unsigned TH = 3;
    localparam int unsigned SW = 16;
    localparam int unsigned SH = 12;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;

    tile_drawer_if bus ();

    tile_drawer #(
        .TILE_W       (TW),
        .TILE_H       (TH),
        .SCREEN_W     (SW),
        .SCREEN_H     (SH),
        .BORDER       (1),
        .BORDER_COLOR (9'h000)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and check every pixel, the done pulse and the return to idle.
    // abort_at >= 0 pulls resetn low while that pixel index is on the outputs.
    task automatic run_cmd(input logic clr, input logic [1:0] tx, input logic [1:0] ty,
                           input logic [8:0] fill, input logic ben, input logic hammer,
                           input int abort_at);
        int unsigned w, h, ox, oy;
        logic [8:0]  ec;
        w  = clr ? SW : TW;
        h  = clr ? SH : TH;
        ox = clr ? 0 : 32'(tx) * TW;
        oy = clr ? 0 : 32'(ty) * TH;
        bus.start      = 1'b1;
        bus.clear      = clr;
        bus.tile_x     = tx;
        bus.tile_y     = ty;
        bus.fill_color = fill;
        bus.border_en  = ben;
        @(posedge clock);
        @(negedge clock);
        bus.start      = hammer;
        bus.clear      = ~clr;
        bus.tile_x     = ~tx;
        bus.tile_y     = ~ty;
        bus.fill_color = ~fill;
        bus.border_en  = ~ben;
        for (int ly = 0; ly < int'(h); ly++) begin
            for (int lx = 0; lx < int'(w); lx++) begin
                if (abort_at == ly * int'(w) + lx) begin
                    resetn = 1'b0;
                    #1;
                    check("abort_flags", {29'd0, bus.busy, bus.write, bus.done}, 32'd0);
                    check("abort_pixel", {3'd0, bus.x, bus.y, bus.color}, 32'd0);
                    @(negedge clock);
                    check("abort_no_done", {29'd0, bus.busy, bus.write, bus.done}, 32'd0);
                    resetn = 1'b1;
                    return;
                end
                ec = (ben && !clr && (lx == 0 || lx == int'(w) - 1 || ly == 0 || ly == int'(h) - 1))
                     ? 9'h000 : fill;
                check("draw_flags", {29'd0, bus.busy, bus.write, bus.done}, 32'b110);
                check("draw_x", 32'(bus.x), ox + 32'(lx));
                check("draw_y", 32'(bus.y), oy + 32'(ly));
                check("draw_color", 32'(bus.color), 32'(ec));
                if (hammer) begin
                    bus.tile_x     = 2'(lx);
                    bus.tile_y     = 2'(ly);
                    bus.fill_color = 9'h007;
                    bus.clear      = 1'(lx);
                end
                @(negedge clock);
            end
        end
        check("done_pulse", {29'd0, bus.busy, bus.write, bus.done}, 32'b001);
        check("done_pixel", {3'd0, bus.x, bus.y, bus.color}, 32'd0);
        @(negedge clock);
        check("back_idle", {29'd0, bus.busy, bus.write, bus.done}, 32'd0);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.clear      = 1'b0;
        bus.tile_x     = 2'd0;
        bus.tile_y     = 2'd0;
        bus.fill_color = 9'h000;
        bus.border_en  = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_state", {1'b0, bus.write, bus.busy, bus.done, bus.x, bus.y, bus.color}, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle", {1'b0, bus.write, bus.busy, bus.done, bus.x, bus.y, bus.color}, 32'd0);
        end

        // Tile (2,1): x 8..11, y 3..5, plain fill
        run_cmd(1'b0, 2'd2, 2'd1, 9'h1C0, 1'b0, 1'b0, -1);
        // Same tile with outline: only (9,4),(10,4) keep the fill
        run_cmd(1'b0, 2'd2, 2'd1, 9'h1C0, 1'b1, 1'b0, -1);
        // Full clear; border_en must be ignored
        run_cmd(1'b1, 2'd3, 2'd2, 9'h1FF, 1'b1, 1'b0, -1);
        // Start held high with changing command during DRAW and DONE: ignored
        run_cmd(1'b0, 2'd1, 2'd2, 9'h038, 1'b1, 1'b1, -1);
        // Back-to-back: start in the first idle cycle after done is accepted
        run_cmd(1'b0, 2'd3, 2'd0, 9'h0AA, 1'b0, 1'b0, -1);
        // Reset at pixel 5 aborts without done, then a full redraw
        run_cmd(1'b0, 2'd2, 2'd1, 9'h1C0, 1'b0, 1'b0, 5);
        @(negedge clock);
        check("post_abort_idle", {1'b0, bus.write, bus.busy, bus.done, bus.x, bus.y, bus.color}, 32'd0);
        run_cmd(1'b0, 2'd2, 2'd1, 9'h1C0, 1'b0, 1'b0, -1);
        // Last tile corner (3,3): x 12..15, y 9..11
        run_cmd(1'b0, 2'd3, 2'd3, 9'h107, 1'b1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
